// File: rtl/onehot32_encoder_seq.sv
// Sequential 32-to-5 encoder: sticky pending capture of request pulses,
// serialised lowest-index-first over a valid/ready handshake.
module onehot32_encoder_seq #(
  parameter int unsigned N_IN  = 32,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   req_i,
  input  logic              clr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_IN-1:0]   pending_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  dup_cnt_o
);

  localparam int unsigned POP_W = IDX_W + 1;
  localparam int unsigned SUM_W = CNT_W + POP_W;

  typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    pend_q, pend_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               pop;
  logic               p_nz;
  logic               load;
  logic [IDX_W-1:0]   sel;
  logic [N_IN-1:0]    sel_mask;
  logic [N_IN-1:0]    dup_hits;
  logic [POP_W-1:0]   dup_inc;
  logic [SUM_W-1:0]   cnt_sum;

  assign pop  = valid_q && ready_i;
  assign p_nz = |pend_q;
  assign load = ((state_q == IDLE) && p_nz) || ((state_q == PRESENT) && pop && p_nz);

  // Lowest set bit of the pending register wins.
  always_comb begin
    sel = '0;
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = IDX_W'(i);
    end
  end

  assign sel_mask = load ? ({{(N_IN-1){1'b0}}, 1'b1} << sel) : '0;
  assign dup_hits = req_i & pend_q & ~sel_mask;

  always_comb begin
    dup_inc = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      dup_inc = dup_inc + POP_W'(dup_hits[i]);
    end
  end

  // Pending update and saturating duplicate counter.
  always_comb begin
    pend_d  = (pend_q & ~sel_mask) | req_i;
    cnt_sum = SUM_W'(cnt_q) + SUM_W'(dup_inc);
    cnt_d   = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(cnt_sum);
    if (clr_i) begin
      pend_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (p_nz) state_d = PRESENT;
      PRESENT: if (pop && !p_nz) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  // Next values of the registered output stage.
  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      idx_d   = sel;
      valid_d = 1'b1;
    end else if ((state_q == PRESENT) && pop) begin
      valid_d = 1'b0;
    end
    if (clr_i) begin
      idx_d   = '0;
      valid_d = 1'b0;
    end
    busy_d = valid_d || (|pend_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_o     = idx_q;
  assign valid_o   = valid_q;
  assign pending_o = pend_q;
  assign busy_o    = busy_q;
  assign dup_cnt_o = cnt_q;

endmodule

// File: tb/tb_onehot32_encoder_seq.sv
// Bench for onehot32_encoder_seq: vector table, corner sequences and a
// randomised run against an event-level reference model.
module tb_onehot32_encoder_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_i;
  logic        clr_i;
  logic [4:0]  idx_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pending_o;
  logic        busy_o;
  logic [7:0]  dup_cnt_o;

  onehot32_encoder_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .clr_i     (clr_i),
    .idx_o     (idx_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pending_o (pending_o),
    .busy_o    (busy_o),
    .dup_cnt_o (dup_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of pending lines, one presented slot, event counter.
  logic [31:0] m_pend;
  logic        m_valid;
  int          m_idx;
  int          m_dup;

  typedef struct {
    logic [31:0] req;
    logic        ready;
    logic [4:0]  idx;
    logic        valid;
    logic [31:0] pend;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int k = 0; k < 32; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_valid = 1'b0; m_idx = 0; m_dup = 0;
  endtask

  task automatic model_step(input logic [31:0] r, input logic rd, input logic c);
    bit pop;
    int taken;
    pop   = m_valid && rd;
    taken = (!m_valid || pop) ? lowest(m_pend) : -1;
    for (int k = 0; k < 32; k++)
      if (r[k] && m_pend[k] && k != taken) m_dup++;
    if (m_dup > 255) m_dup = 255;
    if (taken >= 0) m_pend[taken] = 1'b0;
    m_pend = m_pend | r;
    if (taken >= 0) begin
      m_idx = taken; m_valid = 1'b1;
    end else if (pop) begin
      m_valid = 1'b0;
    end
    if (c) model_reset();
  endtask

  task automatic check_model();
    chk("valid", 32'(valid_o), 32'(m_valid));
    chk("pending", pending_o, m_pend);
    chk("busy", 32'(busy_o), 32'(m_valid || (m_pend != 0)));
    chk("dup_cnt", 32'(dup_cnt_o), 32'(m_dup));
    if (m_valid) chk("idx", 32'(idx_o), 32'(m_idx));
  endtask

  // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
  task automatic cycle(input logic [31:0] r, input logic rd, input logic c);
    req_i = r; ready_i = rd; clr_i = c;
    @(posedge clk);
    model_step(r, rd, c);
    #1;
    check_model();
  endtask

  initial begin
    rst_n = 1'b0; req_i = '0; ready_i = 1'b0; clr_i = 1'b0;
    model_reset();

    // Directed vectors: single event, priority, backpressure, re-arm in flight.
    tbl[0]  = '{32'h0000_0001, 1'b1, 5'd0,  1'b0, 32'h0000_0001};
    tbl[1]  = '{32'h0000_0000, 1'b1, 5'd0,  1'b1, 32'h0000_0000};
    tbl[2]  = '{32'h0000_0000, 1'b1, 5'd0,  1'b0, 32'h0000_0000};
    tbl[3]  = '{32'h8000_0100, 1'b1, 5'd0,  1'b0, 32'h8000_0100};
    tbl[4]  = '{32'h0000_0000, 1'b1, 5'd8,  1'b1, 32'h8000_0000};
    tbl[5]  = '{32'h0000_0000, 1'b1, 5'd31, 1'b1, 32'h0000_0000};
    tbl[6]  = '{32'h0000_0000, 1'b1, 5'd31, 1'b0, 32'h0000_0000};
    tbl[7]  = '{32'h0000_0014, 1'b0, 5'd31, 1'b0, 32'h0000_0014};
    tbl[8]  = '{32'h0000_0000, 1'b0, 5'd2,  1'b1, 32'h0000_0010};
    tbl[9]  = '{32'h0000_0000, 1'b0, 5'd2,  1'b1, 32'h0000_0010};
    tbl[10] = '{32'h0000_0000, 1'b0, 5'd2,  1'b1, 32'h0000_0010};
    tbl[11] = '{32'h0000_0000, 1'b0, 5'd2,  1'b1, 32'h0000_0010};
    tbl[12] = '{32'h0000_0000, 1'b0, 5'd2,  1'b1, 32'h0000_0010};
    tbl[13] = '{32'h0000_0000, 1'b1, 5'd4,  1'b1, 32'h0000_0000};
    tbl[14] = '{32'h0000_0000, 1'b1, 5'd4,  1'b0, 32'h0000_0000};
    tbl[15] = '{32'h0000_0020, 1'b0, 5'd4,  1'b0, 32'h0000_0020};
    tbl[16] = '{32'h0000_0000, 1'b0, 5'd5,  1'b1, 32'h0000_0000};
    tbl[17] = '{32'h0000_0020, 1'b0, 5'd5,  1'b1, 32'h0000_0020};
    tbl[18] = '{32'h0000_0000, 1'b1, 5'd5,  1'b1, 32'h0000_0000};
    tbl[19] = '{32'h0000_0000, 1'b1, 5'd5,  1'b0, 32'h0000_0000};

    #7;
    chk("reset_idx", 32'(idx_o), 32'h0);
    chk("reset_valid", 32'(valid_o), 32'h0);
    chk("reset_pending", pending_o, 32'h0);
    chk("reset_dup", 32'(dup_cnt_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].req, tbl[i].ready, 1'b0);
      chk($sformatf("tbl%0d_idx", i), 32'(idx_o), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pend", i), pending_o, tbl[i].pend);
      chk($sformatf("tbl%0d_dup", i), 32'(dup_cnt_o), 32'h0);
    end

    // Idle with no requests stays quiet.
    for (int i = 0; i < 4; i++) cycle('0, 1'b1, 1'b0);
    chk("idle_busy", 32'(busy_o), 32'h0);

    // Duplicate saturation, then clear colliding with a request.
    cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) cycle(32'h8, 1'b0, 1'b0);
    chk("sat_dup", 32'(dup_cnt_o), 32'd255);
    chk("sat_idx", 32'(idx_o), 32'd3);
    chk("sat_pend", pending_o, 32'h8);
    cycle(32'h8, 1'b0, 1'b1);
    chk("clr_dup", 32'(dup_cnt_o), 32'h0);
    chk("clr_pend", pending_o, 32'h0);
    chk("clr_valid", 32'(valid_o), 32'h0);

    // Full drain: 32 indices on consecutive cycles.
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cycle('0, 1'b1, 1'b0);
      chk("drain_idx", 32'(idx_o), 32'(i));
      chk("drain_valid", 32'(valid_o), 32'h1);
    end
    cycle('0, 1'b1, 1'b0);
    chk("drain_end_valid", 32'(valid_o), 32'h0);
    chk("drain_end_busy", 32'(busy_o), 32'h0);

    // Drain again and hit reset mid-stream, away from any clock edge.
    cycle(32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i <= 10; i++) cycle('0, 1'b1, 1'b0);
    chk("pre_rst_idx", 32'(idx_o), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_idx", 32'(idx_o), 32'h0);
    chk("async_valid", 32'(valid_o), 32'h0);
    chk("async_pend", pending_o, 32'h0);
    chk("async_busy", 32'(busy_o), 32'h0);
    chk("async_dup", 32'(dup_cnt_o), 32'h0);
    model_reset();
    req_i = '0; ready_i = 1'b0; clr_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      if ($urandom_range(0, 9) == 0) r = r | (32'h1 << $urandom_range(0, 3));
      cycle(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 79) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot32_encoder_seq.md
Name: onehot32_encoder_seq

Overview:
- Sequential 32-to-5 encoder: the reverse direction of the team's 5-to-32 decoder tree.
- Captures event pulses on 32 one-hot/multi-hot request lines into a sticky pending register.
- Serialises pending events as 5-bit indices over a valid/ready handshake, one index per accepted transfer, lowest index first.
- Sits between decoded select/interrupt lines and a consumer that needs a binary index (e.g. an index re-fed to the 5-to-32 decoder).

Parameters:
N_IN, 32, number of request lines; only 32 is required to be supported
IDX_W, 5, index width; must equal clog2(N_IN)
CNT_W, 8, width of the saturating duplicate-event counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  32  request pulses; bit k high for one cycle = one event on line k
clr_i  input  1  synchronous clear of pending state, output stage and counter
idx_o  output  5  encoded index of the presented event
valid_o  output  1  idx_o holds a valid event
ready_i  input  1  consumer accepts idx_o when valid_o && ready_i
pending_o  output  32  current pending register P; excludes the in-flight index
busy_o  output  1  valid_o || (P != 0)
dup_cnt_o  output  8  saturating count of events merged into an already-pending bit

Behaviour:
- Reset (rst_n low, asynchronous): P=0, idx_o=0, valid_o=0, dup_cnt_o=0, FSM=IDLE.
- Outputs are registered. No combinational path exists from req_i or ready_i to any output.
- Definitions, all evaluated on the registered P each cycle:
  - pop = valid_o && ready_i.
  - load = (FSM=IDLE && P!=0) || (FSM=PRESENT && pop && P!=0).
  - sel = index of the lowest set bit of P.
- Pending update: P_next = (P & ~(load ? onehot(sel) : 0)) | req_i.
  - A bit is removed from P in the cycle it is loaded into the output stage.
  - A new request on that same index while the index is in flight re-sets the bit and counts as a new event.
- Duplicate counting:
  - dup_cnt increments by popcount(req_i & P & ~(load ? onehot(sel) : 0)).
  - It saturates at 255 and never wraps.
- FSM IDLE:
  - valid_o=0.
  - If P!=0: idx_o<=sel, valid_o<=1, go to PRESENT.
- FSM PRESENT:
  - valid_o=1. idx_o is held stable while ready_i=0.
  - On pop with P!=0: idx_o<=sel, valid_o stays 1. This gives back-to-back transfers, one index per cycle.
  - On pop with P==0: valid_o<=0, go to IDLE.
- Latency:
  - req_i[k] at edge t sets P[k] at t+1.
  - With the FSM idle and no lower-index events pending, idx_o=k with valid_o=1 after edge t+2.
  - A stream of all-32 requests drains in 32 consecutive cycles when ready_i is held at 1.
- Priority: fixed, lowest index wins. A higher index can be starved by repeated lower-index events. This is intended.
- clr_i (synchronous):
  - Next state is P=0, valid_o=0, idx_o=0, dup_cnt=0, FSM=IDLE.
  - clr_i overrides req_i in the same cycle; those requests are dropped.
  - clr_i overrides pop; the transfer is still considered accepted by the consumer.
- Reset asserted mid-transfer: all state is lost immediately. The consumer must ignore valid_o while rst_n is low.
- req_i=0 forever with P=0: the block stays IDLE and outputs stay constant.

Test Plan:
- Reset then single event: req_i=32'h0000_0001 for 1 cycle, ready_i=1 -> idx_o=0, valid_o=1 for exactly 1 cycle, 2 edges after the request; then busy_o=0.
- Priority: req_i=32'h8000_0100 in one cycle, ready_i=1 -> idx_o=8 then 31 on consecutive cycles; pending_o=32'h8000_0000 while 8 is presented.
- Backpressure: req_i=32'h0000_0014, ready_i=0 for 5 cycles -> idx_o=2 and valid_o=1 held stable for all 5 cycles; pending_o=32'h0000_0010; after ready_i=1, outputs 2 then 4.
- Duplicates and saturation: pulse req_i[3] 300 times while ready_i=0 -> dup_cnt_o=255. Then on the next cycle that req_i[3] pulses, clr_i=1 as well -> dup_cnt_o=0, pending_o=0, valid_o=0.
- Re-arm in flight: idx 5 presented, ready_i=0, pulse req_i[5] -> pending_o[5]=1, dup_cnt unchanged; after acceptance, idx_o=5 is presented a second time.
- Full drain plus async reset: req_i=32'hFFFF_FFFF, ready_i=1 -> indices 0..31 in 32 consecutive cycles. Repeat, but drop rst_n at index 10 -> all outputs 0 immediately, without waiting for a clock edge.
